simd_issue_wb: RTL and testbench

//  Issue/writeback controller for the packed 2x4-bit SIMD add/sub unit.

---
 rtl/simd_issue_wb.sv | 129 ++++++++++++
 tb/tb_simd_issue_wb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_issue_wb.sv
// Issue/writeback controller for the packed 2x4-bit SIMD add/sub unit.
// Sequences IDLE -> READ -> EXEC -> WB around an internal 4x8-bit register file.
module simd_issue_wb #(
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [1:0] instr_op,
  input  logic [1:0] instr_rd,
  input  logic [1:0] instr_rs1,
  input  logic [1:0] instr_rs2,
  input  logic [7:0] instr_imm,
  output logic [7:0] alu_in1,
  output logic [7:0] alu_in2,
  output logic [1:0] alu_add_or_sub,
  input  logic [7:0] alu_out,
  output logic       wb_valid,
  output logic [1:0] wb_rd,
  output logic [7:0] wb_data,
  output logic       err,
  input  logic [1:0] dbg_rsel,
  output logic [7:0] dbg_rdata
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [2:0] CNT_INIT = 3'(ALU_LAT - 1);

  state_t     state;
  logic [1:0] op_q;
  logic [1:0] rd_q;
  logic [1:0] rs1_q;
  logic [1:0] rs2_q;
  logic [7:0] imm_q;
  logic [7:0] result;
  logic [2:0] cnt;
  logic [7:0] regs [4];

  assign dbg_rdata = regs[dbg_rsel];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      instr_ready    <= 1'b0;
      op_q           <= '0;
      rd_q           <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      imm_q          <= '0;
      result         <= '0;
      cnt            <= '0;
      alu_in1        <= '0;
      alu_in2        <= '0;
      alu_add_or_sub <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      err            <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      wb_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            op_q        <= instr_op;
            rd_q        <= instr_rd;
            rs1_q       <= instr_rs1;
            rs2_q       <= instr_rs2;
            imm_q       <= instr_imm;
            instr_ready <= 1'b0;
            state       <= READ;
          end else begin
            instr_ready <= 1'b1;
          end
        end
        READ: begin
          alu_in1 <= regs[rs1_q];
          alu_in2 <= regs[rs2_q];
          case (op_q)
            OP_ADD, OP_SUB: begin
              cnt            <= CNT_INIT;
              alu_add_or_sub <= op_q;
              state          <= EXEC;
            end
            OP_LDI: begin
              result   <= imm_q;
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              wb_data  <= imm_q;
              state    <= WB;
            end
            default: begin
              // Illegal opcode: flag it and drop the instruction without writing.
              err         <= 1'b1;
              instr_ready <= 1'b1;
              state       <= IDLE;
            end
          endcase
        end
        EXEC: begin
          if (cnt == 3'd0) begin
            result         <= alu_out;
            alu_add_or_sub <= 2'b00;
            wb_valid       <= 1'b1;
            wb_rd          <= rd_q;
            wb_data        <= alu_out;
            state          <= WB;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        WB: begin
          // The write lands before the next READ can happen, so no forwarding path.
          regs[rd_q]  <= result;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_issue_wb.sv
// Directed bench for simd_issue_wb with a behavioural 2x4-bit lane add/sub unit
// wired to the ALU ports.
module tb_simd_issue_wb;

  localparam int LAT = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] instr_op, instr_rd, instr_rs1, instr_rs2;
  logic [7:0] instr_imm;
  logic [7:0] alu_in1, alu_in2, alu_out;
  logic [1:0] alu_add_or_sub;
  logic       wb_valid;
  logic [1:0] wb_rd;
  logic [7:0] wb_data;
  logic       err;
  logic [1:0] dbg_rsel;
  logic [7:0] dbg_rdata;

  int n_cmp = 0;
  int n_fail = 0;

  simd_issue_wb #(.ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_add_or_sub(alu_add_or_sub),
    .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .err(err),
    .dbg_rsel(dbg_rsel), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  // Lane-wise unit: each nibble wraps mod 16, no carry/borrow between lanes.
  logic [3:0] la, lb;
  always_comb begin
    la = '0;
    lb = '0;
    if (alu_add_or_sub[0]) begin
      la = alu_in1[7:4] - alu_in2[7:4];
      lb = alu_in1[3:0] - alu_in2[3:0];
    end else begin
      la = alu_in1[7:4] + alu_in2[7:4];
      lb = alu_in1[3:0] + alu_in2[3:0];
    end
    alu_out = {la, lb};
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  task automatic read_dbg(input logic [1:0] sel, output logic [7:0] data);
    dbg_rsel = sel;
    #1;
    data = dbg_rdata;
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                           input logic [1:0] rs2, input logic [7:0] imm,
                           output int n_wb, output int n_err, output int wb_k,
                           output logic [1:0] got_rd, output logic [7:0] got_data,
                           output logic rdy0);
    int w;
    w = 0;
    @(negedge clk);
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", instr_ready, 1);
    instr_valid = 1'b1;
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    rdy0 = instr_ready;
    n_wb = 0; n_err = 0; wb_k = -1; got_rd = '0; got_data = '0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (wb_valid) begin
        n_wb++;
        if (wb_k < 0) wb_k = k;
        got_rd = wb_rd;
        got_data = wb_data;
      end
      if (err) n_err++;
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [7:0] imm;
    logic       exp_wb;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[11];

  logic [1:0] b_op[3], b_rd[3], b_rs1[3], b_rs2[3];
  logic [7:0] b_imm[3], b_exp[3];

  task automatic apply_b2b(input int i);
    instr_op = b_op[i]; instr_rd = b_rd[i]; instr_rs1 = b_rs1[i];
    instr_rs2 = b_rs2[i]; instr_imm = b_imm[i];
  endtask

  initial begin
    int n_wb, n_err, wb_k, acc, wbn, extra;
    logic [1:0] got_rd;
    logic [7:0] got_data, d;
    logic rdy0, take;
    logic [7:0] exp_regs[4];

    // {op, rd, rs1, rs2, imm, exp_wb, exp_data, exp_err}; k counts edges after acceptance
    vecs[0]  = '{2'b10, 2'd1, 2'd0, 2'd0, 8'h35, 1'b1, 8'h35, 1'b0};
    vecs[1]  = '{2'b10, 2'd2, 2'd0, 2'd0, 8'h12, 1'b1, 8'h12, 1'b0};
    vecs[2]  = '{2'b00, 2'd3, 2'd1, 2'd2, 8'h00, 1'b1, 8'h47, 1'b0};
    vecs[3]  = '{2'b01, 2'd0, 2'd2, 2'd1, 8'h00, 1'b1, 8'hED, 1'b0};
    vecs[4]  = '{2'b10, 2'd1, 2'd0, 2'd0, 8'h7F, 1'b1, 8'h7F, 1'b0};
    vecs[5]  = '{2'b10, 2'd2, 2'd0, 2'd0, 8'h11, 1'b1, 8'h11, 1'b0};
    vecs[6]  = '{2'b00, 2'd3, 2'd1, 2'd2, 8'h00, 1'b1, 8'h80, 1'b0};
    vecs[7]  = '{2'b10, 2'd1, 2'd0, 2'd0, 8'h80, 1'b1, 8'h80, 1'b0};
    vecs[8]  = '{2'b10, 2'd2, 2'd0, 2'd0, 8'h10, 1'b1, 8'h10, 1'b0};
    vecs[9]  = '{2'b01, 2'd3, 2'd1, 2'd2, 8'h00, 1'b1, 8'h70, 1'b0};
    vecs[10] = '{2'b11, 2'd0, 2'd1, 2'd2, 8'hFF, 1'b0, 8'h00, 1'b1};
    exp_regs[0] = 8'hED; exp_regs[1] = 8'h80; exp_regs[2] = 8'h10; exp_regs[3] = 8'h70;

    b_op[0] = 2'b10; b_rd[0] = 2'd1; b_rs1[0] = 2'd0; b_rs2[0] = 2'd0; b_imm[0] = 8'h23; b_exp[0] = 8'h23;
    b_op[1] = 2'b00; b_rd[1] = 2'd1; b_rs1[1] = 2'd1; b_rs2[1] = 2'd1; b_imm[1] = 8'h00; b_exp[1] = 8'h46;
    b_op[2] = 2'b00; b_rd[2] = 2'd1; b_rs1[2] = 2'd1; b_rs2[2] = 2'd1; b_imm[2] = 8'h00; b_exp[2] = 8'h8C;

    rst = 1'b0;
    instr_valid = 1'b0;
    instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0;
    dbg_rsel = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", instr_ready, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_err", err, 0);
    check("rst_aos", alu_add_or_sub, 0);
    check("rst_in1", alu_in1, 0);
    for (int r = 0; r < 4; r++) begin
      read_dbg(2'(r), d);
      check($sformatf("rst_reg%0d", r), d, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", instr_ready, 1);

    // Table-driven single instructions
    for (int i = 0; i < 11; i++) begin
      run_instr(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
                n_wb, n_err, wb_k, got_rd, got_data, rdy0);
      check($sformatf("v%0d_ready_busy", i), rdy0, 0);
      check($sformatf("v%0d_wb_count", i), n_wb, vecs[i].exp_wb ? 1 : 0);
      check($sformatf("v%0d_err_count", i), n_err, vecs[i].exp_err ? 1 : 0);
      if (vecs[i].exp_wb) begin
        check($sformatf("v%0d_wb_rd", i), got_rd, vecs[i].rd);
        check($sformatf("v%0d_wb_data", i), got_data, vecs[i].exp_data);
        check($sformatf("v%0d_latency", i), wb_k, (vecs[i].op == 2'b10) ? 1 : LAT + 1);
      end
    end
    for (int r = 0; r < 4; r++) begin
      read_dbg(2'(r), d);
      check($sformatf("tbl_reg%0d", r), d, exp_regs[r]);
    end

    // Back-to-back with instr_valid held high, rd == rs1
    @(negedge clk);
    instr_valid = 1'b1;
    apply_b2b(0);
    acc = 0;
    wbn = 0;
    for (int c = 0; c < 40 && wbn < 3; c++) begin
      take = instr_ready && instr_valid;
      @(posedge clk);
      #1;
      if (wb_valid) begin
        check($sformatf("b2b_wb%0d_data", wbn), wb_data, (wbn < 3) ? b_exp[wbn] : 8'h00);
        check($sformatf("b2b_wb%0d_ready", wbn), instr_ready, 0);
        wbn++;
      end
      if (take) begin
        acc++;
        check($sformatf("b2b_acc%0d_ready", acc), instr_ready, 0);
        if (acc < 3) apply_b2b(acc);
        else instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    extra = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (wb_valid) extra++;
    end
    check("b2b_accepts", acc, 3);
    check("b2b_wb_count", wbn, 3);
    check("b2b_extra_wb", extra, 0);
    read_dbg(2'd1, d);
    check("b2b_r1", d, 8'h8C);

    // Reset during EXEC of ADD r3 = r1 + r2
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op = 2'b00; instr_rd = 2'd3; instr_rs1 = 2'd1; instr_rs2 = 2'd2;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    check("exec_in1", alu_in1, 8'h8C);
    #2;
    rst = 1'b0;
    #1;
    check("arst_ready", instr_ready, 0);
    check("arst_wb_valid", wb_valid, 0);
    check("arst_in1", alu_in1, 0);
    check("arst_in2", alu_in2, 0);
    check("arst_aos", alu_add_or_sub, 0);
    for (int r = 0; r < 4; r++) begin
      read_dbg(2'(r), d);
      check($sformatf("arst_reg%0d", r), d, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (wb_valid || err) extra++;
    end
    check("arst_no_wb", extra, 0);
    check("arst_ready_back", instr_ready, 1);
    run_instr(2'b10, 2'd2, 2'd0, 2'd0, 8'h9C, n_wb, n_err, wb_k, got_rd, got_data, rdy0);
    check("arst_ldi_wb_count", n_wb, 1);
    check("arst_ldi_data", got_data, 8'h9C);
    check("arst_ldi_rd", got_rd, 2'd2);
    read_dbg(2'd2, d);
    check("arst_r2", d, 8'h9C);
    read_dbg(2'd3, d);
    check("arst_r3", d, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
